// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the store-sink data cache.
// Default geometry: 4 lines x 4 words, 16-byte lines.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EVICT  = 2'd2,
        FILL   = 2'd3
    } state_t;

    localparam int DEF_LINES = 4;
    localparam int DEF_WORDS = 4;
    localparam int DEF_OFF_W = $clog2(DEF_WORDS * 4);
    localparam int DEF_IDX_W = $clog2(DEF_LINES);
    localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_OFF_W;

    typedef logic [DEF_WORDS*32-1:0] line_t;

    // Helpers return 32-bit fields; callers size-cast to the width they need.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
        return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] tag, input logic [31:0] idx,
                                              input int off_w, input int idx_w);
        return (tag << (off_w + idx_w)) | (idx << off_w);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: two combinational read ports (load, FSM)
// and one write port that updates either a single word or a whole line.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int WSEL_W = (DEF_WORDS > 1) ? $clog2(DEF_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IDX_W-1:0]       ld_idx,
    output logic                   ld_valid,
    output logic [TAG_W-1:0]       ld_tag,
    output logic [WORDS*32-1:0]    ld_line,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [WORDS*32-1:0]    rd_line,
    input  logic                   we,
    input  logic                   full,
    input  logic [IDX_W-1:0]       w_idx,
    input  logic [TAG_W-1:0]       w_tag,
    input  logic [WSEL_W-1:0]      w_word,
    input  logic [31:0]            w_wdata,
    input  logic [WORDS*32-1:0]    w_line
);

    logic [LINES-1:0]          valid_q;
    logic [LINES-1:0]          dirty_q;
    logic [TAG_W-1:0]          tag_q  [LINES];
    logic [WORDS*32-1:0]       data_q [LINES];

    assign ld_valid = valid_q[ld_idx];
    assign ld_tag   = tag_q[ld_idx];
    assign ld_line  = data_q[ld_idx];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Only the state bits are reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            dirty_q[w_idx] <= 1'b1;
            if (full) valid_q[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (full) begin
                data_q[w_idx] <= w_line;
                tag_q[w_idx]  <= w_tag;
            end else begin
                data_q[w_idx][{w_word, 5'b0} +: 32] <= w_wdata;
            end
        end
    end

endmodule

// File: rtl/dcache_store_sink.sv
// Store-buffer drain receiver committing beats into a direct-mapped write-back cache.
// Optional counters: define DCACHE_STORE_SINK_STATS_EN for stat_hits/stat_misses/stat_evicts.
module dcache_store_sink
    import dcache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    output logic                cache_ready_to_catch,
    input  logic                sending_data_to_cache,
    input  logic [63:0]         data_to_cache,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [WORDS*32-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [WORDS*32-1:0] mem_rdata,
    input  logic [31:0]         ld_addr,
    output logic                ld_hit,
    output logic [31:0]         ld_data,
    output logic                busy,
    output logic                drop_err,
`ifdef DCACHE_STORE_SINK_STATS_EN
    output logic [15:0]         stat_hits,
    output logic [15:0]         stat_misses,
    output logic [15:0]         stat_evicts,
`endif
    output state_t              dbg_state
);

    localparam int OFF_W  = $clog2(WORDS * 4);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Drain handshake: a beat is sending_data_to_cache=1 at a posedge; the sender
    // only launches a beat after sampling cache_ready_to_catch=1. A beat that
    // still arrives with the skid full is dropped and flagged in drop_err.
    state_t               state_q;
    logic                 work_valid_q, skid_valid_q;
    logic [31:0]          work_addr_q, work_data_q, skid_addr_q, skid_data_q;
    logic                 mem_req_q, mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [WORDS*32-1:0]  mem_wdata_q;
    logic                 drop_err_q;

    logic [TAG_W-1:0]     work_tag, ld_tag_a, arr_ld_tag, rd_tag;
    logic [IDX_W-1:0]     work_idx, ld_idx;
    logic [WSEL_W-1:0]    work_word, ld_word;
    logic                 arr_ld_valid, rd_valid, rd_dirty;
    logic [WORDS*32-1:0]  arr_ld_line, rd_line, fill_line;
    logic                 beat, to_work, lookup_hit, fill_done, retire;
    logic                 arr_we, arr_full;

    assign work_tag  = TAG_W'(addr_tag(work_addr_q, OFF_W, IDX_W));
    assign work_idx  = IDX_W'(addr_idx(work_addr_q, OFF_W, IDX_W));
    assign work_word = WSEL_W'(addr_word(work_addr_q, OFF_W));
    assign ld_tag_a  = TAG_W'(addr_tag(ld_addr, OFF_W, IDX_W));
    assign ld_idx    = IDX_W'(addr_idx(ld_addr, OFF_W, IDX_W));
    assign ld_word   = WSEL_W'(addr_word(ld_addr, OFF_W));

    dcache_line_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .WSEL_W (WSEL_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .ld_idx   (ld_idx),
        .ld_valid (arr_ld_valid),
        .ld_tag   (arr_ld_tag),
        .ld_line  (arr_ld_line),
        .rd_idx   (work_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (arr_we),
        .full     (arr_full),
        .w_idx    (work_idx),
        .w_tag    (work_tag),
        .w_word   (work_word),
        .w_wdata  (work_data_q),
        .w_line   (fill_line)
    );

    assign beat       = sending_data_to_cache;
    assign to_work    = beat && (state_q == IDLE) && !work_valid_q;
    assign lookup_hit = rd_valid && (rd_tag == work_tag);
    assign fill_done  = (state_q == FILL) && mem_req_q && mem_ack;
    assign retire     = ((state_q == LOOKUP) && lookup_hit) || fill_done;
    assign arr_we     = retire;
    assign arr_full   = (state_q == FILL);

    // Fill data with the pending store word merged over the fetched line.
    always_comb begin
        fill_line = mem_rdata;
        fill_line[{work_word, 5'b0} +: 32] = work_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            work_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            work_addr_q  <= '0;
            work_data_q  <= '0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            if (beat) begin
                if (to_work) begin
                    work_addr_q  <= data_to_cache[63:32];
                    work_data_q  <= data_to_cache[31:0];
                    work_valid_q <= 1'b1;
                end else if (skid_valid_q) begin
                    drop_err_q <= 1'b1;
                end else begin
                    skid_addr_q  <= data_to_cache[63:32];
                    skid_data_q  <= data_to_cache[31:0];
                    skid_valid_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (work_valid_q) state_q <= LOOKUP;
                end
                LOOKUP: begin
                    if (!lookup_hit) begin
                        mem_req_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q     <= EVICT;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= line_base(32'(rd_tag), 32'(work_idx), OFF_W, IDX_W);
                            mem_wdata_q <= rd_line;
                        end else begin
                            state_q     <= FILL;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= line_base(32'(work_tag), 32'(work_idx), OFF_W, IDX_W);
                            mem_wdata_q <= '0;
                        end
                    end
                end
                EVICT: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    // After a write-back the request line idles one cycle before the fill issues.
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= line_base(32'(work_tag), 32'(work_idx), OFF_W, IDX_W);
                        mem_wdata_q <= '0;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Retire overrides the capture above: the skid (or a beat landing now) becomes work.
            if (retire) begin
                if (skid_valid_q) begin
                    work_addr_q  <= skid_addr_q;
                    work_data_q  <= skid_data_q;
                    skid_valid_q <= 1'b0;
                    state_q      <= LOOKUP;
                end else if (beat) begin
                    work_addr_q  <= data_to_cache[63:32];
                    work_data_q  <= data_to_cache[31:0];
                    skid_valid_q <= 1'b0;
                    state_q      <= LOOKUP;
                end else begin
                    work_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            end
        end
    end

`ifdef DCACHE_STORE_SINK_STATS_EN
    logic [15:0] stat_hits_q, stat_misses_q, stat_evicts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_evicts_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (lookup_hit) begin
                if (stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
            end else begin
                if (stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
                if (rd_valid && rd_dirty && stat_evicts_q != 16'hFFFF)
                    stat_evicts_q <= stat_evicts_q + 16'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_evicts = stat_evicts_q;
`endif

    assign cache_ready_to_catch = (state_q == IDLE) && !skid_valid_q;
    assign busy      = (state_q != IDLE) || skid_valid_q;
    assign drop_err  = drop_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_hit    = arr_ld_valid && (arr_ld_tag == ld_tag_a);
    assign ld_data   = ld_hit ? arr_ld_line[{ld_word, 5'b0} +: 32] : 32'd0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_store_sink.sv
// Scenario bench for dcache_store_sink: memory requests are scoreboarded
// through exp_q, load-port results are checked inline per scenario.
module tb_dcache_store_sink;
    import dcache_pkg::*;

    localparam int WORDS = DEF_WORDS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cache_ready_to_catch;
    logic                sending_data_to_cache = 1'b0;
    logic [63:0]         data_to_cache = '0;
    logic                mem_req, mem_we;
    logic [31:0]         mem_addr;
    logic [WORDS*32-1:0] mem_wdata;
    logic                mem_ack = 1'b0;
    logic [WORDS*32-1:0] mem_rdata = '0;
    logic [31:0]         ld_addr = '0;
    logic                ld_hit;
    logic [31:0]         ld_data;
    logic                busy, drop_err;
    state_t              dbg_state;
`ifdef DCACHE_STORE_SINK_STATS_EN
    logic [15:0]         stat_hits, stat_misses, stat_evicts;
`endif

    logic [32:0] exp_q[$];   // expected memory requests: {we, line address}
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcache_store_sink dut (
        .clk                   (clk),
        .reset                 (reset),
        .cache_ready_to_catch  (cache_ready_to_catch),
        .sending_data_to_cache (sending_data_to_cache),
        .data_to_cache         (data_to_cache),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata),
        .ld_addr               (ld_addr),
        .ld_hit                (ld_hit),
        .ld_data               (ld_data),
        .busy                  (busy),
        .drop_err              (drop_err),
`ifdef DCACHE_STORE_SINK_STATS_EN
        .stat_hits             (stat_hits),
        .stat_misses           (stat_misses),
        .stat_evicts           (stat_evicts),
`endif
        .dbg_state             (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        while (cache_ready_to_catch !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (cache_ready_to_catch !== 1'b1) begin
            n_err++;
            $display("FAIL beat_ready: got %b expected 1 (addr %h)", cache_ready_to_catch, a);
        end
        sending_data_to_cache = 1'b1;
        data_to_cache = {a, d};
        @(negedge clk);
        sending_data_to_cache = 1'b0;
    endtask

    task automatic serve_mem(input logic [WORDS*32-1:0] rdata, input logic [WORDS*32-1:0] exp_wdata);
        int t = 0;
        logic [32:0] e;
        int hold;
        while (mem_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL mem_req_timeout: got %b expected 1", mem_req);
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL mem_unexpected: got we=%b addr=%h expected no request", mem_we, mem_addr);
            e = {mem_we, mem_addr};
        end else begin
            e = exp_q.pop_front();
            if ({mem_we, mem_addr} !== e) begin
                n_err++;
                $display("FAIL mem_req_fields: got we=%b addr=%h expected we=%b addr=%h",
                         mem_we, mem_addr, e[32], e[31:0]);
            end
        end
        if (e[32]) begin
            n_cmp++;
            if (mem_wdata !== exp_wdata) begin
                n_err++;
                $display("FAIL mem_wdata: got %h expected %h", mem_wdata, exp_wdata);
            end
        end
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL mem_stable: got req=%b we=%b addr=%h expected req=1 we=%b addr=%h",
                         mem_req, mem_we, mem_addr, e[32], e[31:0]);
            end
        end
        mem_ack = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL mem_req_drop: got %b expected 0", mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cache_ready_to_catch, busy, drop_err, mem_req, mem_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/busy/drop/req/we=%b expected 10000",
                     {cache_ready_to_catch, busy, drop_err, mem_req, mem_we});
        end
        n_cmp++;
        if (mem_addr !== 32'd0 || mem_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        ld_addr = 32'h40;
        #1;
        n_cmp++;
        if ({ld_hit, ld_data} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_ld: got hit=%b data=%h expected 0/0", ld_hit, ld_data);
        end
    endtask

    task automatic test_clean_miss();
        exp_q.push_back({1'b0, 32'h40});
        send_beat(32'h40, 32'hDEAD_BEEF);
        serve_mem('0, '0);
        ld_addr = 32'h40;
        @(negedge clk);
        n_cmp++;
        if ({ld_hit, ld_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL miss_ld40: got hit=%b data=%h expected 1/deadbeef", ld_hit, ld_data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL miss_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_hit_latency();
        logic saw_req = 1'b0;
        ld_addr = 32'h44;
        send_beat(32'h44, 32'h1234_5678);
        saw_req |= mem_req;
        @(negedge clk);
        saw_req |= mem_req;
        n_cmp++;
        if ({ld_data, cache_ready_to_catch} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL hit_early: got data=%h rdy=%b expected 0/0", ld_data, cache_ready_to_catch);
        end
        @(negedge clk);
        saw_req |= mem_req;
        n_cmp++;
        if ({ld_data, cache_ready_to_catch} !== {32'h1234_5678, 1'b1}) begin
            n_err++;
            $display("FAIL hit_commit: got data=%h rdy=%b expected 12345678/1", ld_data, cache_ready_to_catch);
        end
        n_cmp++;
        if (saw_req !== 1'b0) begin
            n_err++;
            $display("FAIL hit_no_mem: got mem_req seen=%b expected 0", saw_req);
        end
        ld_addr = 32'h48;
        #1;
        n_cmp++;
        if ({ld_hit, ld_data} !== {1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL hit_ld48: got hit=%b data=%h expected 1/0", ld_hit, ld_data);
        end
    endtask

    task automatic test_dirty_evict();
        line_t victim, rd;
        victim = {32'd0, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF};
        rd = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back({1'b1, 32'h40});
        exp_q.push_back({1'b0, 32'h80});
        send_beat(32'h80, 32'hCAFE_F00D);
        serve_mem('0, victim);
        serve_mem(rd, '0);
        ld_addr = 32'h40;
        #1;
        n_cmp++;
        if ({ld_hit, ld_data} !== 33'd0) begin
            n_err++;
            $display("FAIL evict_ld40: got hit=%b data=%h expected 0/0", ld_hit, ld_data);
        end
        ld_addr = 32'h80;
        #1;
        n_cmp++;
        if ({ld_hit, ld_data} !== {1'b1, 32'hCAFE_F00D}) begin
            n_err++;
            $display("FAIL evict_ld80: got hit=%b data=%h expected 1/cafef00d", ld_hit, ld_data);
        end
        ld_addr = 32'h84;
        #1;
        n_cmp++;
        if (ld_data !== rd[63:32]) begin
            n_err++;
            $display("FAIL fill_merge: got %h expected %h", ld_data, rd[63:32]);
        end
`ifdef DCACHE_STORE_SINK_STATS_EN
        n_cmp++;
        if ({stat_hits, stat_misses, stat_evicts} !== {16'd1, 16'd2, 16'd1}) begin
            n_err++;
            $display("FAIL stats: got h=%0d m=%0d e=%0d expected 1/2/1", stat_hits, stat_misses, stat_evicts);
        end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        exp_q.push_back({1'b0, 32'h10});
        sending_data_to_cache = 1'b1;
        data_to_cache = {32'h10, 32'd1};
        @(negedge clk);
        n_cmp++;
        if (cache_ready_to_catch !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b expected 1", cache_ready_to_catch);
        end
        data_to_cache = {32'h14, 32'd2};
        @(negedge clk);
        sending_data_to_cache = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy: got %b expected 1", busy);
        end
        serve_mem('0, '0);
        repeat (4) @(negedge clk);
        ld_addr = 32'h10;
        #1;
        n_cmp++;
        if (ld_data !== 32'd1) begin
            n_err++;
            $display("FAIL b2b_ld10: got %h expected 1", ld_data);
        end
        ld_addr = 32'h14;
        #1;
        n_cmp++;
        if (ld_data !== 32'd2) begin
            n_err++;
            $display("FAIL b2b_ld14: got %h expected 2", ld_data);
        end
        n_cmp++;
        if ({drop_err, busy, mem_req} !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_idle: got drop/busy/req=%b expected 000", {drop_err, busy, mem_req});
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] va, vb;
        va = $urandom;
        vb = $urandom;
        sending_data_to_cache = 1'b1;
        data_to_cache = {32'h18, va};
        @(negedge clk);
        data_to_cache = {32'h18, vb};
        @(negedge clk);
        sending_data_to_cache = 1'b0;
        repeat (5) @(negedge clk);
        ld_addr = 32'h18;
        #1;
        n_cmp++;
        if (ld_data !== vb) begin
            n_err++;
            $display("FAIL same_addr_order: got %h expected %h", ld_data, vb);
        end
    endtask

    task automatic test_drop();
        sending_data_to_cache = 1'b1;
        data_to_cache = {32'h1C, 32'd7};
        @(negedge clk);
        data_to_cache = {32'h1C, 32'd8};
        @(negedge clk);
        data_to_cache = {32'h1C, 32'd9};
        @(negedge clk);
        sending_data_to_cache = 1'b0;
        n_cmp++;
        if (drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_set: got %b expected 1", drop_err);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (drop_err !== 1'b1) begin
            n_err++;
            $display("FAIL drop_sticky: got %b expected 1", drop_err);
        end
        ld_addr = 32'h1C;
        #1;
        n_cmp++;
        if (ld_data !== 32'd8) begin
            n_err++;
            $display("FAIL drop_ld1c: got %h expected 8", ld_data);
        end
    endtask

    task automatic test_reset_mid_evict();
        int t = 0;
        int bad = 0;
        logic [32:0] e;
        exp_q.push_back({1'b1, 32'h10});
        send_beat(32'h50, 32'h55);
        while (mem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        e = exp_q.pop_front();
        if ({mem_req, mem_we, mem_addr} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL evict2_req: got req=%b we=%b addr=%h expected 1/%b/%h",
                     mem_req, mem_we, mem_addr, e[32], e[31:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({mem_req, cache_ready_to_catch, busy, drop_err} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_evict_flags: got req/rdy/busy/drop=%b expected 0100",
                     {mem_req, cache_ready_to_catch, busy, drop_err});
        end
        for (int a = 0; a < 256; a += 4) begin
            ld_addr = 32'(a);
            #1;
            if (ld_hit !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_evict_ld: got %0d hitting addresses expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_hit_latency();
        test_dirty_evict();
        test_back_to_back();
        test_same_addr();
        test_drop();
        test_reset_mid_evict();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_q_drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_store_sink.md
Name: dcache_store_sink

Overview:
- Cache-side receiver for store-buffer drains. It accepts {address, data} beats from the store buffer's drain interface (cache_ready_to_catch / sending_data_to_cache / data_to_cache) and commits each beat into a small direct-mapped, write-back, write-allocate data cache.
- On a miss it writes back a dirty victim line and then fills the line from the memory port.
- A combinational load-lookup port exposes cache hits to the load path.

Parameters:
- LINES, 4, number of cache lines; power of 2, minimum 2.
- WORDS, 4, 32-bit words per line; power of 2.
- Derived: OFF_W=log2(WORDS*4), IDX_W=log2(LINES), TAG_W=32-IDX_W-OFF_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cache_ready_to_catch  out  1  sink can accept a beat
- sending_data_to_cache  in  1  beat valid this cycle
- data_to_cache  in  64  [63:32] byte address, [31:0] store data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line write-back, 0 = line fill
- mem_addr  out  32  line-aligned address (low OFF_W bits = 0)
- mem_wdata  out  WORDS*32  victim line data
- mem_ack  in  1  request done; mem_rdata valid this cycle for reads
- mem_rdata  in  WORDS*32  fill data, word 0 in the LSBs
- ld_addr  in  32  load lookup address
- ld_hit  out  1  combinational: valid line with matching tag
- ld_data  out  32  hit word, 0 on miss
- busy  out  1  state != IDLE or skid valid
- drop_err  out  1  sticky: a beat arrived with the skid already full

Behaviour:
- Clock and reset: clk, with reset synchronous, active-high.
- Address split: word = addr[OFF_W-1:2], idx = addr[OFF_W+IDX_W-1:OFF_W], tag = upper bits. addr[1:0] is ignored (whole-word stores only).
- Beat definition: sending_data_to_cache=1 at a posedge. Contract: the sender drives a beat only after sampling ready=1.
- Ready: cache_ready_to_catch = (state==IDLE) && !skid_valid, computed combinationally from registers.
- Beat capture:
  - In IDLE with work empty, a beat goes into the work register.
  - Any other beat goes into the 1-entry skid.
  - A beat arriving with the skid full is discarded and sets drop_err until reset.
- FSM states: IDLE, LOOKUP, EVICT, FILL.
  - IDLE: on capture, go to LOOKUP next cycle.
  - LOOKUP, hit: write the word, set dirty, retire.
  - LOOKUP, miss with victim valid and dirty: go to EVICT.
  - LOOKUP, miss otherwise: go to FILL.
  - EVICT: mem_req=1, mem_we=1, mem_addr={victim tag, idx, 0}, mem_wdata=victim line. On mem_ack, go to FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr={work tag, idx, 0}. On mem_ack, write mem_rdata with the store word merged in, set tag, valid=1, dirty=1, then retire.
  - Retire: if the skid is valid, move it into work and go to LOOKUP; otherwise go to IDLE.
- Memory handshake:
  - mem_req/mem_we/mem_addr/mem_wdata are registered and stable from the first request cycle until the ack cycle inclusive.
  - mem_req drops the cycle after ack.
  - mem_ack is ignored when mem_req=0.
- Latency:
  - Hit: beat at edge N, line updated at edge N+2, ready high after N+2.
  - Clean miss: 2 cycles plus fill wait.
  - Dirty miss: adds the write-back wait.
- Ordering: beats commit strictly in arrival order. Same-address back-to-back beats: the later value wins.
- Load port:
  - Pure lookup of the array state; never triggers a fill.
  - A store's data is visible on ld_data the cycle after its line write.
- Reset values:
  - All valid/dirty = 0, state = IDLE, work/skid invalid.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, drop_err=0, busy=0, ready=1.
  - Reset mid-EVICT/FILL abandons the transaction: mem_req=0 the next cycle and dirty data is lost by design.

Optional Feature:
- DCACHE_STORE_SINK_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_evicts. Each is 16 bits, saturating at 0xFFFF, cleared by reset, and increments once per LOOKUP hit, LOOKUP miss, and EVICT entry respectively.
- Undefined: these ports and counters do not exist.

Decomposition:
- dcache_pkg holds:
  - state enum {IDLE, LOOKUP, EVICT, FILL};
  - derived width constants;
  - line_t (WORDS x 32 packed);
  - function helpers to extract tag/idx/word.
- Sub-module dcache_line_array:
  - holds tag/valid/dirty/data storage;
  - one combinational read port for loads and one for the FSM;
  - one write port (word write or full-line write);
  - reset clears valid/dirty.

Test Plan:
- Reset, then beat {0x0000_0040, 0xDEAD_BEEF} -> FILL read with mem_addr=0x40, mem_we=0. Ack with rdata=0 -> ld_addr 0x40 gives ld_hit=1, ld_data=0xDEAD_BEEF; busy returns to 0.
- Then beat {0x44, 0x1234_5678} -> no mem_req; line updated 2 cycles after the beat; ld 0x44 returns 0x1234_5678; ld 0x48 returns 0.
- Then beat {0x80, 0xCAFE_F00D} (same idx, new tag):
  - expect EVICT write with mem_addr=0x40 and wdata words 0,1 = DEADBEEF, 12345678;
  - then FILL read at 0x80;
  - ld 0x40 misses, ld 0x80 hits.
- Beats on 2 consecutive cycles {0x10,1}, {0x14,2} -> second held in skid, both committed in order, drop_err=0. Drive a third beat while the skid is full -> drop_err=1 and sticky.
- Assert reset during EVICT with mem_req high -> next cycle mem_req=0, ready=1, busy=0, ld_hit=0 for every address.
- With DCACHE_STORE_SINK_STATS_EN, run the first three scenarios -> stat_hits=1, stat_misses=2, stat_evicts=1.
